// File: rtl/readout_seq_pkg.sv
// Shared types and defaults for the analog-bank readout sequencer.
// Holds the FSM state encoding and the idle value of the byte address.
package readout_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHIPRST,
    RUN,
    SELECT,
    CAPTURE,
    DONE
  } rs_state_t;

  localparam logic [2:0] SELECT_IDLE = 3'b111;

  localparam int NUM_CH_DEF        = 8;
  localparam int BYTES_PER_CH_DEF  = 7;
  localparam int SETTLE_CYC_DEF    = 2;
  localparam int RST_PULSE_CYC_DEF = 4;

endpackage

// File: rtl/readout_sequencer_next_ch_finder.sv
// Combinational search for the lowest set mask bit at or above a start index.
// The start index is one bit wider than a channel index so "past the last channel" never wraps.
module next_ch_finder #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [IDX_W:0]    start,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_CH-1:0] hit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
    assign hit[gi] = mask[gi] && (start <= (IDX_W+1)'(gi));
  end

  // Walk downwards so the last assignment wins with the lowest hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// Run control and byte-by-byte readout of the analog register bank.
// Every output is registered; the comb block computes next state, counters and outputs.
module readout_sequencer
  import readout_seq_pkg::*;
#(
  parameter int NUM_CH        = NUM_CH_DEF,
  parameter int BYTES_PER_CH  = BYTES_PER_CH_DEF,
  parameter int SETTLE_CYC    = SETTLE_CYC_DEF,
  parameter int RST_PULSE_CYC = RST_PULSE_CYC_DEF
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              inst_rst,
  input  logic              inst_start,
  input  logic              inst_readout,
  input  logic [NUM_CH-1:0] trigger_channel_mask,
  input  logic [7:0]        ana_data,
  input  logic              byte_ready,
  output logic [NUM_CH-1:0] load_cnt_ser,
  output logic [2:0]        select_reg,
  output logic              sample_en,
  output logic              chip_rst,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic [2:0]        byte_ch,
  output logic [2:0]        byte_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);
  localparam logic [3:0] PULSE_LAST  = 4'(RST_PULSE_CYC - 1);
  localparam logic [2:0] IDX_LAST    = 3'(BYTES_PER_CH - 1);

  rs_state_t         state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [NUM_CH-1:0] mask_reg, mask_next;
  logic [2:0]        ch_reg, ch_next;
  logic [2:0]        idx_reg, idx_next;

  logic [NUM_CH-1:0] load_reg, load_next;
  logic [2:0]        select_reg_q, select_next;
  logic              sample_reg, sample_next;
  logic              chip_rst_reg, chip_rst_next;
  logic              valid_reg, valid_next;
  logic [7:0]        data_reg, data_next;
  logic [2:0]        byte_ch_reg, byte_ch_next;
  logic [2:0]        byte_idx_reg, byte_idx_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic       first_found, next_found;
  logic [2:0] first_ch, next_ch;

  next_ch_finder #(.NUM_CH(NUM_CH), .IDX_W(3)) u_first (
    .mask  (trigger_channel_mask),
    .start (4'd0),
    .found (first_found),
    .idx   (first_ch)
  );

  next_ch_finder #(.NUM_CH(NUM_CH), .IDX_W(3)) u_next (
    .mask  (mask_reg),
    .start ({1'b0, ch_reg} + 4'd1),
    .found (next_found),
    .idx   (next_ch)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mask_next     = mask_reg;
    ch_next       = ch_reg;
    idx_next      = idx_reg;
    valid_next    = valid_reg;
    data_next     = data_reg;
    byte_ch_next  = byte_ch_reg;
    byte_idx_next = byte_idx_reg;

    if (inst_rst) begin
      state_next = CHIPRST;
      cnt_next   = 4'd0;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE, RUN: begin
          if (inst_readout) begin
            // The mask is frozen here; later changes only affect the next readout.
            mask_next = trigger_channel_mask;
            cnt_next  = 4'd0;
            ch_next   = first_ch;
            idx_next  = 3'd0;
            state_next = first_found ? SELECT : DONE;
          end else if (inst_start && state_reg == IDLE) begin
            state_next = RUN;
          end
        end
        CHIPRST: begin
          if (cnt_reg == PULSE_LAST) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        SELECT: begin
          if (cnt_reg == SETTLE_LAST) begin
            state_next    = CAPTURE;
            cnt_next      = 4'd0;
            valid_next    = 1'b1;
            data_next     = ana_data;
            byte_ch_next  = ch_reg;
            byte_idx_next = idx_reg;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        CAPTURE: begin
          if (valid_reg && byte_ready) begin
            valid_next = 1'b0;
            cnt_next   = 4'd0;
            if (idx_reg < IDX_LAST) begin
              idx_next   = idx_reg + 3'd1;
              state_next = SELECT;
            end else if (next_found) begin
              ch_next    = next_ch;
              idx_next   = 3'd0;
              state_next = SELECT;
            end else begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          valid_next = 1'b0;
        end
      endcase
    end

    // Registered outputs are decoded from the state being entered.
    load_next     = '0;
    select_next   = SELECT_IDLE;
    sample_next   = 1'b0;
    chip_rst_next = 1'b0;
    done_next     = 1'b0;
    busy_next     = 1'b1;
    case (state_next)
      IDLE:    busy_next = 1'b0;
      RUN: begin
        busy_next   = 1'b0;
        sample_next = 1'b1;
      end
      CHIPRST: chip_rst_next = 1'b1;
      SELECT, CAPTURE: begin
        load_next   = ONE_HOT0 << ch_next;
        select_next = idx_next;
      end
      DONE:    done_next = 1'b1;
      default: busy_next = 1'b1;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      mask_reg     <= '0;
      ch_reg       <= 3'd0;
      idx_reg      <= 3'd0;
      load_reg     <= '0;
      select_reg_q <= SELECT_IDLE;
      sample_reg   <= 1'b0;
      chip_rst_reg <= 1'b0;
      valid_reg    <= 1'b0;
      data_reg     <= 8'd0;
      byte_ch_reg  <= 3'd0;
      byte_idx_reg <= 3'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mask_reg     <= mask_next;
      ch_reg       <= ch_next;
      idx_reg      <= idx_next;
      load_reg     <= load_next;
      select_reg_q <= select_next;
      sample_reg   <= sample_next;
      chip_rst_reg <= chip_rst_next;
      valid_reg    <= valid_next;
      data_reg     <= data_next;
      byte_ch_reg  <= byte_ch_next;
      byte_idx_reg <= byte_idx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign load_cnt_ser = load_reg;
  assign select_reg   = select_reg_q;
  assign sample_en    = sample_reg;
  assign chip_rst     = chip_rst_reg;
  assign byte_valid   = valid_reg;
  assign byte_data    = data_reg;
  assign byte_ch      = byte_ch_reg;
  assign byte_idx     = byte_idx_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule
